// File: rtl/pb_io_pkg.sv
// Shared constants for the PicoBlaze I/O peripherals: port map, IRQ state
// encoding and the default debounce prescale.
package pb_io_pkg;

    localparam logic [7:0] PB_PORT_SW1    = 8'h00;
    localparam logic [7:0] PB_PORT_SW2    = 8'h01;
    localparam logic [7:0] PB_PORT_CHG1   = 8'h02;
    localparam logic [7:0] PB_PORT_CHG2   = 8'h03;
    localparam logic [7:0] PB_PORT_STATUS = 8'h04;

    localparam int PB_DEBOUNCE_CYCLES_DEFAULT = 100000;
    localparam int PB_PRESCALE_W              = 20;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_ACKD = 2'd2
    } irq_state_e;

endpackage

// File: rtl/pb_switch_reader_if.sv
// KCPSM6 input-port bus: port address, read qualifier, read data and the
// interrupt request/acknowledge pair.
interface pb_switch_reader_if;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, read_strobe, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, read_strobe, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/pb_debounce_bank.sv
// One switch bank: 2-flop synchroniser, 3-sample history taken on the shared
// tick, and a stable register that moves only when all samples agree.
module pb_debounce_bank #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] db
);

    logic [WIDTH-1:0]        sync1_q, sync1_d;
    logic [WIDTH-1:0]        sync2_q, sync2_d;
    logic [2:0][WIDTH-1:0]   hist_q, hist_d;
    logic [WIDTH-1:0]        db_q, db_d;
    logic [WIDTH-1:0]        all1, all0;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        hist_d  = hist_q;
        if (tick) begin
            hist_d = {hist_q[1], hist_q[0], sync2_q};
        end
        // Bits whose history is mixed keep their previous stable value.
        all1 = hist_q[0] & hist_q[1] & hist_q[2];
        all0 = ~(hist_q[0] | hist_q[1] | hist_q[2]);
        db_d = (db_q | all1) & ~all0;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            db_q    <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/pb_switch_reader.sv
// Debounced switch reader for KCPSM6: two banks, sticky change flags with
// clear-on-read, registered read mux. Interrupt FSM built only when
// PB_SWITCH_READER_IRQ_EN is defined; otherwise firmware polls port 0x04.
module pb_switch_reader
    import pb_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [7:0]           sw1,
    input  logic [7:0]           sw2,
    pb_switch_reader_if.slave    bus
);

    logic [PB_PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                     tick;
    logic [7:0]               db1, db2;
    logic [7:0]               db1_p_q, db1_p_d, db2_p_q, db2_p_d;
    logic [7:0]               chg1_q, chg1_d, chg2_q, chg2_d;
    logic [7:0]               in_port_q, in_port_d;
    logic                     rd_chg1, rd_chg2;

    pb_debounce_bank #(.WIDTH(8)) u_bank1 (
        .CLK  (CLK),
        .rst  (rst),
        .tick (tick),
        .raw  (sw1),
        .db   (db1)
    );

    pb_debounce_bank #(.WIDTH(8)) u_bank2 (
        .CLK  (CLK),
        .rst  (rst),
        .tick (tick),
        .raw  (sw2),
        .db   (db2)
    );

    always_comb begin
        tick    = (cnt_q == PB_PRESCALE_W'(DEBOUNCE_CYCLES - 1));
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        db1_p_d = db1;
        db2_p_d = db2;
        rd_chg1 = bus.read_strobe && (bus.port_id == PB_PORT_CHG1);
        rd_chg2 = bus.read_strobe && (bus.port_id == PB_PORT_CHG2);
        // A change landing on the clearing edge survives the clear.
        chg1_d  = (rd_chg1 ? 8'h00 : chg1_q) | (db1 ^ db1_p_q);
        chg2_d  = (rd_chg2 ? 8'h00 : chg2_q) | (db2 ^ db2_p_q);
        case (bus.port_id)
            PB_PORT_SW1:    in_port_d = db1;
            PB_PORT_SW2:    in_port_d = db2;
            PB_PORT_CHG1:   in_port_d = chg1_q;
            PB_PORT_CHG2:   in_port_d = chg2_q;
            PB_PORT_STATUS: in_port_d = {6'b0, |chg2_q, |chg1_q};
            default:        in_port_d = db1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_q     <= '0;
            db1_p_q   <= '0;
            db2_p_q   <= '0;
            chg1_q    <= '0;
            chg2_q    <= '0;
            in_port_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            db1_p_q   <= db1_p_d;
            db2_p_q   <= db2_p_d;
            chg1_q    <= chg1_d;
            chg2_q    <= chg2_d;
            in_port_q <= in_port_d;
        end
    end

    assign bus.in_port = in_port_q;

`ifdef PB_SWITCH_READER_IRQ_EN
    irq_state_e state_q, state_d;
    logic       any_flag;

    always_comb begin
        any_flag = (|chg1_q) || (|chg2_q);
        state_d  = state_q;
        case (state_q)
            IRQ_IDLE: if (any_flag)          state_d = IRQ_REQ;
            IRQ_REQ:  if (bus.interrupt_ack) state_d = IRQ_ACKD;
            // Hold off re-requesting until firmware has drained every flag.
            IRQ_ACKD: if (!any_flag)         state_d = IRQ_IDLE;
            default:                         state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) state_q <= IRQ_IDLE;
        else     state_q <= state_d;
    end

    assign bus.interrupt = (state_q == IRQ_REQ);
`else
    logic unused_ack;
    assign unused_ack    = bus.interrupt_ack;
    assign bus.interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_pb_switch_reader.sv
// Directed bench for pb_switch_reader with DEBOUNCE_CYCLES=4; expected values
// queued at stimulus time and checked by a negedge monitor.
module tb_pb_switch_reader;

    logic       CLK;
    logic       rst;
    logic [7:0] sw1, sw2;
    logic [1:0] probe;   // 1: check in_port, 2: check interrupt
    int         ecnt;
    int         errors;
    int         checks;

    logic [7:0] exp_q[$];
    string      name_q[$];

    pb_switch_reader_if bus ();

    pb_switch_reader #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK (CLK),
        .rst (rst),
        .sw1 (sw1),
        .sw2 (sw2),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edges since reset release; prescaler ticks land on multiples of 4.
    always @(posedge CLK) ecnt <= rst ? 0 : ecnt + 1;

    always @(negedge CLK) begin
        if (bus.read_strobe || probe != 2'd0) begin
            logic [7:0] e, act;
            string      n;
            act = (probe == 2'd2) ? {7'b0, bus.interrupt} : bus.in_port;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got 0x%02h with no expectation queued", act);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h", n, act, e);
                end
            end
        end
    end

    task automatic expect_val(input logic [7:0] v, input string n);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    // KCPSM6 INPUT: port_id for one cycle, then held with read_strobe.
    task automatic rd(input logic [7:0] addr, input logic [7:0] v, input string n);
        bus.port_id = addr;
        @(posedge CLK); #1;
        bus.read_strobe = 1'b1;
        expect_val(v, n);
        @(posedge CLK); #1;
        bus.read_strobe = 1'b0;
    endtask

    task automatic chk(input logic [1:0] kind, input logic [7:0] v, input string n);
        probe = kind;
        expect_val(v, n);
        @(posedge CLK); #1;
        probe = 2'd0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic align();
        do begin
            @(posedge CLK); #1;
        end while (ecnt % 4 != 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        probe  = 2'd0;
        rst    = 1'b1;
        sw1    = 8'hFF;
        sw2    = 8'h00;
        bus.port_id       = 8'h00;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;

        // Reset held three cycles
        cycles(1);
        chk(2'd1, 8'h00, "reset_in_port");
        chk(2'd2, 8'h00, "reset_interrupt");
        rst = 1'b0;
        cycles(20);
        rd(8'h00, 8'hFF, "reset_db1");
        rd(8'h04, 8'h01, "status_after_reset");
        rd(8'h02, 8'hFF, "chg1_after_reset");
        rd(8'h02, 8'h00, "chg1_cleared");

        // Short glitch on sw2[3] is rejected, held level is accepted
        sw2 = 8'h08; cycles(5); sw2 = 8'h00;
        cycles(20);
        rd(8'h01, 8'h00, "glitch_db2");
        rd(8'h03, 8'h00, "glitch_chg2");
        sw2 = 8'h08;
        cycles(20);
        rd(8'h01, 8'h08, "held_db2");
        rd(8'h04, 8'h02, "status_chg2");
        rd(8'h03, 8'h08, "held_chg2");
        rd(8'h04, 8'h00, "status_drained");

        // Clear-on-read with chg1 = 0x81
        sw1 = 8'h7E;
        cycles(20);
        rd(8'h02, 8'h81, "chg1_read");
        rd(8'h02, 8'h00, "chg1_reread");
        rd(8'h00, 8'h7E, "db1_7e");

        // Address decode
        sw2 = 8'h0C;
        cycles(20);
        rd(8'h04, 8'h02, "status_decode");
        rd(8'h7F, 8'h7E, "addr_7f_db1");
        rd(8'h05, 8'h7E, "addr_05_db1");
        rd(8'h03, 8'h04, "chg2_bit2");

        // Set and clear on the same edge: flag lands at t0+14
        sw1 = 8'h7F;
        cycles(20);
        align();
        sw1 = 8'h6F;
        cycles(12);
        rd(8'h02, 8'h01, "simul_read");
        rd(8'h02, 8'h10, "simul_after");
        rd(8'h00, 8'h6F, "simul_db1");

`ifdef PB_SWITCH_READER_IRQ_EN
        bus.interrupt_ack = 1'b1; cycles(1); bus.interrupt_ack = 1'b0;
        cycles(1);
        chk(2'd2, 8'h00, "irq_idle");
        align();
        sw1 = 8'h6E;
        cycles(14);
        chk(2'd2, 8'h00, "irq_before_flag");
        chk(2'd2, 8'h01, "irq_raised");
        bus.interrupt_ack = 1'b1; cycles(1); bus.interrupt_ack = 1'b0;
        chk(2'd2, 8'h00, "irq_acked");
        sw1 = 8'h6C;
        cycles(20);
        chk(2'd2, 8'h00, "irq_held_off");
        rd(8'h02, 8'h03, "irq_drain_chg1");
        rd(8'h03, 8'h00, "irq_drain_chg2");
        chk(2'd2, 8'h00, "irq_drained");
        sw2 = 8'h0D;
        cycles(20);
        chk(2'd2, 8'h01, "irq_rearmed");
`else
        sw1 = 8'h6E;
        bus.interrupt_ack = 1'b1; cycles(1); bus.interrupt_ack = 1'b0;
        cycles(20);
        chk(2'd2, 8'h00, "irq_tied_low");
        rd(8'h04, 8'h01, "poll_status");
        rd(8'h02, 8'h01, "poll_chg1");
`endif

        // Mid-operation reset
        rst = 1'b1;
        cycles(1);
        chk(2'd1, 8'h00, "midrst_in_port");
        chk(2'd2, 8'h00, "midrst_interrupt");
        rst = 1'b0;
        rd(8'h00, 8'h00, "midrst_db1");
        rd(8'h03, 8'h00, "midrst_chg2");

        cycles(2);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pb_switch_reader.md
# pb_switch_reader

Input-side peripheral for the PicoBlaze (KCPSM6) system: the read counterpart of the 7-segment output path. It synchronises and debounces two 8-bit switch banks, latches per-bit change events, and returns the selected register on `in_port` for processor `INPUT` instructions. It sits between the board switches and the processor's `port_id`/`read_strobe`/`in_port` and `interrupt`/`interrupt_ack` pins, and replaces the ad-hoc input multiplexer in the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: clock cycles between debounce sample ticks (1 ms at 100 MHz); legal range 2..2^20.
- `CLK` in 1: system clock, shared with the processor.
- `rst` in 1: synchronous, active-high reset.
- `sw1` in 8: raw switch bank 1, asynchronous.
- `sw2` in 8: raw switch bank 2, asynchronous.
- `port_id` in 8: processor port address.
- `read_strobe` in 1: processor read qualifier.
- `in_port` out 8: registered read data to the processor.
- `interrupt` out 1: level interrupt request.
- `interrupt_ack` in 1: processor acknowledge, one-cycle pulse.

## Operation
- Synchroniser: each raw bit passes through 2 flip-flops.
- Prescaler: a 20-bit counter produces `tick` for one cycle every `DEBOUNCE_CYCLES` cycles.
- Debounce: on each `tick`, every bit shifts into a 3-deep history. The stable value `db[i]` updates only when all 3 samples agree.
- Change flags `chg1`/`chg2`: bit i is set on the cycle its `db` value changes, in either direction. It is sticky until read.
- Register map, decoded from `port_id`:
  - 0x00: `db1`.
  - 0x01: `db2`.
  - 0x02: `chg1`.
  - 0x03: `chg2`.
  - 0x04: `{6'b0, |chg2, |chg1}`.
  - Any other address: returns `db1`.
- Clear-on-read: at a clock edge with `read_strobe`=1 and `port_id`=0x02 or 0x03, the addressed flag register is cleared.
- Simultaneous events: a change arriving in the same cycle as a clear wins. That bit ends up set, and all other bits end up cleared.
- Interrupt FSM has three states:
  - IDLE → REQ when any flag is set.
  - REQ (`interrupt`=1) → ACKD on `interrupt_ack`.
  - ACKD (`interrupt`=0) → IDLE when `chg1` and `chg2` are both zero.
  - No new request is raised until the flags have been drained.

## Timing
- Reset values:
  - `in_port`=0x00, `interrupt`=0, FSM=IDLE.
  - `db1`, `db2`, all histories, `chg1`, `chg2`, synchronisers and prescaler = 0.
- `rst` asserted mid-operation returns every register to its reset value on the next edge.
- Read data: `in_port` is registered from `port_id` every cycle, so it has 1-cycle latency. It is valid during the `read_strobe` cycle because KCPSM6 holds `port_id` for 2 cycles.
- Input-to-`db` latency: 2 cycles (synchroniser) plus 2 to 3 ticks.
- Input-to-flag latency: 1 cycle after the `db` change.
- Flag-to-`interrupt` latency: 1 cycle.
- `interrupt` deasserts on the edge after `interrupt_ack`.
- Prescaler wraps from `DEBOUNCE_CYCLES`-1 to 0. It runs freely and is not restarted by input activity.
- Glitches shorter than 2 ticks never reach `db`.

## Configuration
- `PB_SWITCH_READER_IRQ_EN` defined: the interrupt FSM is built as described above.
- Undefined: the FSM is not built. `interrupt` is tied to 0 and `interrupt_ack` is ignored. Flags and the status register at 0x04 still operate, so firmware polls.

## Structure
- Shared package `pb_io_pkg` holds:
  - Port address constants (`PB_PORT_SW1`=0x00 … `PB_PORT_STATUS`=0x04).
  - The IRQ state encoding (IDLE=2'd0, REQ=2'd1, ACKD=2'd2).
  - The default `DEBOUNCE_CYCLES`.
- Sub-module `pb_debounce_bank`, parameter `WIDTH`=8: contains the synchroniser, 3-sample history and stable register for one bank. It is instantiated twice, with `tick` shared from the parent.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.
- Reset: hold `rst` 3 cycles with `sw1`=0xFF → `in_port`=0x00, `interrupt`=0. About 14 cycles after release, reading 0x00 returns 0xFF.
- Debounce: pulse `sw2[3]` high for 5 cycles (less than 2 ticks) → reading 0x01 stays 0x00 and `chg2` stays 0x00. Hold it 20 cycles → 0x01 reads 0x08.
- Clear-on-read: with `chg1`=0x81, read port 0x02 → `in_port`=0x81 in the strobe cycle. A second read returns 0x00.
- Simultaneous set/clear: `chg1`=0x01 and `db1[4]` changes on the same edge as the read-strobe of 0x02 → afterwards `chg1`=0x10.
- Interrupt handshake (macro defined): flag set → `interrupt`=1 the next cycle. `interrupt_ack` pulse → `interrupt`=0 the next cycle, and it stays 0 while a new change occurs before the flags are read. Reading 0x02 and 0x03 until both are zero, then one more change → `interrupt`=1.
- Address decode: `port_id`=0x04 with `chg2`≠0 and `chg1`=0 → `in_port`=0x02. `port_id`=0x7F → returns `db1`.
